fft_delay_commutator: RTL and testbench

- Parametrised successor to the FFT 2x2 complex switch: a delay-commutator built from delay lines and a counter-driven swap.
- Reorders two complex streams between radix-2 MDC pipeline stages.
- Delay depth D is runtime-selectable (2^cfg_log2_d), so one instance serves every stage of the 8~2048-point multipoint FFT.
- Sits between butterfly stages; valid-qualified streaming, no backpressure.

---
 rtl/fft_pkg.sv | 13 +
 rtl/fft_var_delay.sv | 55 +++++
 rtl/fft_delay_commutator.sv | 191 +++++++++++++++++++
 tb/tb_fft_delay_commutator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT delay-commutator slice.
package fft_pkg;

    localparam int FFT_DW         = 16;
    localparam int FFT_MAX_LOG2_D = 10;
    localparam int FFT_CNT_W      = FFT_MAX_LOG2_D + 1;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_var_delay.sv
// Runtime-length delay line: a circular buffer of depth 2^MAX_LOG2_D whose
// pointer wraps at D, giving exactly D steps of delay between din and dout.
module fft_var_delay
    import fft_pkg::*;
#(
    parameter int W          = 2 * FFT_DW,
    parameter int MAX_LOG2_D = FFT_MAX_LOG2_D
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            step_i,
    input  logic                            sync_i,
    input  logic [$clog2(MAX_LOG2_D+1)-1:0] log2_d_i,
    input  logic [W-1:0]                    din_i,
    output logic [W-1:0]                    dout_o
);

    localparam int DEPTH = 1 << MAX_LOG2_D;
    localparam int AW    = MAX_LOG2_D;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic [AW-1:0] ptr_base;
    logic [AW-1:0] ptr_last;

    // A sync step restarts the buffer at slot 0 and also writes into it.
    assign ptr_base = sync_i ? '0 : ptr_q;
    assign ptr_last = AW'((32'd1 << log2_d_i) - 32'd1);

    // Read-before-write of the same slot yields the value written D steps ago.
    assign dout_o = mem_q[ptr_base];

    always_comb begin
        ptr_d = ptr_q;
        if (step_i) begin
            ptr_d = (ptr_base == ptr_last) ? '0 : ptr_base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (step_i) begin
            mem_q[ptr_base] <= din_i;
        end
    end

endmodule

// File: rtl/fft_delay_commutator.sv
// Radix-2 MDC delay-commutator with runtime depth D = 2^cfg_log2_d.
// Optional FFT_COMM_BYPASS_EN adds a per-frame straight-through bypass.
module fft_delay_commutator
    import fft_pkg::*;
#(
    parameter int DW         = FFT_DW,
    parameter int MAX_LOG2_D = FFT_MAX_LOG2_D
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(MAX_LOG2_D+1)-1:0] cfg_log2_d,
    input  logic                            in_valid,
    input  logic                            in_sop,
    input  logic                            flush,
`ifdef FFT_COMM_BYPASS_EN
    input  logic                            bypass,
`endif
    input  logic [DW-1:0]                   x0_re,
    input  logic [DW-1:0]                   x0_im,
    input  logic [DW-1:0]                   x1_re,
    input  logic [DW-1:0]                   x1_im,
    output logic                            out_valid,
    output logic                            out_sop,
    output logic [DW-1:0]                   y0_re,
    output logic [DW-1:0]                   y0_im,
    output logic [DW-1:0]                   y1_re,
    output logic [DW-1:0]                   y1_im
);

    localparam int LW = $clog2(MAX_LOG2_D + 1);
    localparam int CW = MAX_LOG2_D + 1;
    localparam int PW = 2 * DW;

    logic          step;
    logic          sync;
    logic [LW-1:0] cfg_clamped;
    logic [LW-1:0] log2_d_q;
    logic [LW-1:0] log2_d_d;
    logic [LW-1:0] log2_eff;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_mask;
    logic [CW-1:0] fill_q;
    logic [CW-1:0] fill_d;
    logic [CW-1:0] fill_base;
    logic [CW-1:0] d_len;
    logic          pend_q;
    logic          pend_d;
    logic          pend_base;
    logic          out_valid_q;
    logic          out_valid_d;
    logic          out_sop_q;
    logic          out_sop_d;
    logic [PW-1:0] y0_q;
    logic [PW-1:0] y0_d;
    logic [PW-1:0] y1_q;
    logic [PW-1:0] y1_d;
    logic [PW-1:0] x0_s;
    logic [PW-1:0] x1_s;
    logic [PW-1:0] x1_dly;
    logic [PW-1:0] u0;
    logic [PW-1:0] u1;
    logic [PW-1:0] u0_dly;
    logic          sel;
    logic          emit;

    assign step = in_valid | flush;
    assign sync = in_valid & in_sop;

    // Out-of-range depths are clamped so the swap-select index stays in range.
    assign cfg_clamped = (cfg_log2_d > LW'(MAX_LOG2_D)) ? LW'(MAX_LOG2_D) : cfg_log2_d;
    assign log2_eff    = sync ? cfg_clamped : log2_d_q;
    assign d_len       = CW'(32'd1 << log2_eff);
    assign cnt_mask    = CW'((32'd1 << (log2_eff + 1)) - 32'd1);

    // The sync pair is step 0 of the new frame, so counters start from zero.
    assign cnt_base  = sync ? '0 : cnt_q;
    assign fill_base = sync ? '0 : fill_q;
    assign pend_base = sync | pend_q;
    assign emit      = (fill_base == d_len);
    assign sel       = cnt_base[log2_eff];

    assign x0_s = in_valid ? {x0_re, x0_im} : '0;
    assign x1_s = in_valid ? {x1_re, x1_im} : '0;

    fft_var_delay #(
        .W          (PW),
        .MAX_LOG2_D (MAX_LOG2_D)
    ) u_pre_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_i   (step),
        .sync_i   (sync),
        .log2_d_i (log2_eff),
        .din_i    (x1_s),
        .dout_o   (x1_dly)
    );

    // Second half of each block swaps the fresh x0 with the delayed x1.
    assign u0 = sel ? x1_dly : x0_s;
    assign u1 = sel ? x0_s   : x1_dly;

    fft_var_delay #(
        .W          (PW),
        .MAX_LOG2_D (MAX_LOG2_D)
    ) u_post_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_i   (step),
        .sync_i   (sync),
        .log2_d_i (log2_eff),
        .din_i    (u0),
        .dout_o   (u0_dly)
    );

`ifdef FFT_COMM_BYPASS_EN
    logic byp_q;
    logic byp_eff;

    assign byp_eff = sync ? bypass : byp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q <= 1'b0;
        end else if (step) begin
            byp_q <= byp_eff;
        end
    end
`endif

    always_comb begin
        log2_d_d    = log2_d_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        pend_d      = pend_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        y0_d        = y0_q;
        y1_d        = y1_q;
        if (step) begin
            log2_d_d = log2_eff;
            cnt_d    = (cnt_base + 1'b1) & cnt_mask;
            fill_d   = emit ? fill_base : fill_base + 1'b1;
            pend_d   = pend_base & ~emit;
            if (emit) begin
                out_valid_d = 1'b1;
                out_sop_d   = pend_base;
                y0_d        = u0_dly;
                y1_d        = u1;
            end
`ifdef FFT_COMM_BYPASS_EN
            if (byp_eff) begin
                out_valid_d = 1'b1;
                out_sop_d   = sync;
                pend_d      = 1'b0;
                y0_d        = x0_s;
                y1_d        = x1_s;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log2_d_q    <= '0;
            cnt_q       <= '0;
            fill_q      <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            y0_q        <= '0;
            y1_q        <= '0;
        end else begin
            log2_d_q    <= log2_d_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_sop        = out_sop_q;
    assign {y0_re, y0_im} = y0_q;
    assign {y1_re, y1_im} = y1_q;

endmodule

// File: tb/tb_fft_delay_commutator.sv
// Directed bench for fft_delay_commutator with a block-mapping reference model
// feeding an expected-output queue.
module tb_fft_delay_commutator;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int MAXL = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    cfg_log2_d = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          flush = 1'b0;
  logic          byp_in = 1'b0;
  logic [DW-1:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0;
  logic          out_valid, out_sop;
  logic [DW-1:0] y0_re, y0_im, y1_re, y1_im;

  fft_delay_commutator #(.DW(DW), .MAX_LOG2_D(MAXL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_log2_d (cfg_log2_d),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .flush      (flush),
`ifdef FFT_COMM_BYPASS_EN
    .bypass     (byp_in),
`endif
    .x0_re      (x0_re),
    .x0_im      (x0_im),
    .x1_re      (x1_re),
    .x1_im      (x1_im),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .y0_re      (y0_re),
    .y0_im      (y0_im),
    .y1_re      (y1_re),
    .y1_im      (y1_im)
  );

  // scoreboard and reference model state
  logic [64:0] exp_q[$];
  logic [31:0] m_a [0:511];
  logic [31:0] m_b [0:511];
  int          m_s = 0;
  int          m_d = 1;
  logic        m_byp = 1'b0;
  logic [63:0] last_y = '0;
  logic        exp_v;
  logic        exp_idle;
  int          checks = 0;
  int          errors = 0;

  function automatic cplx_t mk(input int re, input int im);
    cplx_t c;
    c.re = 16'(re);
    c.im = 16'(im);
    return c;
  endfunction

  function automatic logic [31:0] rnd();
    return $urandom();
  endfunction

  task automatic model_reset();
    m_s = 0;
    m_d = 1;
    m_byp = 1'b0;
    last_y = '0;
  endtask

  // One clock: apply inputs, update the model, then check outputs at negedge.
  task automatic drive(input logic v, input logic sop, input logic fl,
                       input logic [3:0] cfg, input logic [31:0] a, input logic [31:0] b);
    int j, base, jj;
    logic [63:0] e;
    logic [64:0] ent;
    logic [63:0] obs_y;
    in_valid = v; in_sop = sop; flush = fl; cfg_log2_d = cfg;
    {x0_re, x0_im} = a;
    {x1_re, x1_im} = b;
    exp_v = 1'b0;
    exp_idle = !(v || fl);
    if (v || fl) begin
      if (v && sop) begin
        m_s = 0;
        m_d = 1 << cfg;
        m_byp = byp_in;
      end
      m_a[m_s] = v ? a : 32'd0;
      m_b[m_s] = v ? b : 32'd0;
      if (m_byp) begin
        exp_q.push_back({v && sop, m_a[m_s], m_b[m_s]});
        exp_v = 1'b1;
      end else if (m_s >= m_d) begin
        j = m_s - m_d;
        base = (j / (2 * m_d)) * (2 * m_d);
        jj = j - base;
        if (jj < m_d) e = {m_a[base + jj], m_a[base + jj + m_d]};
        else          e = {m_b[base + jj - m_d], m_b[base + jj]};
        exp_q.push_back({(j == 0), e});
        exp_v = 1'b1;
      end
      m_s++;
    end
    @(posedge clk);
    @(negedge clk);
    obs_y = {y0_re, y0_im, y1_re, y1_im};
    checks++;
    assert (out_valid === exp_v) else begin
      errors++; $error("FAIL out_valid obs=%b exp=%b t=%0t", out_valid, exp_v, $time);
    end
    if (exp_idle) begin
      checks++;
      assert (obs_y === last_y) else begin
        errors++; $error("FAIL hold obs=%h exp=%h t=%0t", obs_y, last_y, $time);
      end
    end
    if (out_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++; $error("FAIL underflow obs=%0d exp=>0 t=%0t", exp_q.size(), $time);
      end
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        checks++;
        assert (obs_y === ent[63:0]) else begin
          errors++; $error("FAIL data obs=%h exp=%h t=%0t", obs_y, ent[63:0], $time);
        end
        checks++;
        assert (out_sop === ent[64]) else begin
          errors++; $error("FAIL out_sop obs=%b exp=%b t=%0t", out_sop, ent[64], $time);
        end
      end
      last_y = obs_y;
    end else begin
      if (exp_v && exp_q.size() > 0) void'(exp_q.pop_front());
      checks++;
      assert (out_sop === 1'b0) else begin
        errors++; $error("FAIL out_sop_idle obs=%b exp=0 t=%0t", out_sop, $time);
      end
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid obs=%b exp=0", out_valid); end
    checks++; assert (out_sop === 1'b0) else begin errors++; $error("FAIL rst_sop obs=%b exp=0", out_sop); end
    checks++; assert ({y0_re, y0_im} === 32'd0) else begin errors++; $error("FAIL rst_y0 obs=%h exp=0", {y0_re, y0_im}); end
    checks++; assert ({y1_re, y1_im} === 32'd0) else begin errors++; $error("FAIL rst_y1 obs=%h exp=0", {y1_re, y1_im}); end
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0, rnd(), rnd());

    // D=1 transpose
    drive(1'b1, 1'b1, 1'b0, 4'd0, mk(1, -1), mk(2, -2));
    drive(1'b1, 1'b0, 1'b0, 4'd0, mk(3, -3), mk(4, -4));
    drive(1'b1, 1'b0, 1'b0, 4'd0, mk(5, -5), mk(6, -6));
    drive(1'b1, 1'b0, 1'b0, 4'd0, mk(7, -7), mk(8, -8));
    drive(1'b0, 1'b0, 1'b1, 4'd0, rnd(), rnd());
    drive(1'b0, 1'b0, 1'b0, 4'd0, rnd(), rnd());

    // D=4 block, one step with flush and valid together, then end-of-stream flush
    for (int k = 0; k < 8; k++)
      drive(1'b1, k == 0, k == 2, 4'd2, mk(k, -3 * k), mk(100 + k, 7 * k - 20));
    for (int k = 0; k < 8; k++)
      drive(1'b0, 1'b0, 1'b1, 4'd2, rnd(), rnd());
    drive(1'b0, 1'b0, 1'b0, 4'd2, rnd(), rnd());

    // D=2 gapped 1-of-3, stray sop on idle cycles, cfg changes without sop
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, k == 0, 1'b0, (k < 4) ? 4'd1 : 4'd5, mk(20 + k, -k), mk(-50 - k, k));
      drive(1'b0, 1'b1, 1'b0, 4'd5, rnd(), rnd());
      drive(1'b0, 1'b0, 1'b0, 4'd1, rnd(), rnd());
    end
    drive(1'b0, 1'b0, 1'b1, 4'd5, rnd(), rnd());
    drive(1'b0, 1'b0, 1'b1, 4'd5, rnd(), rnd());

    // mid-frame resync from D=4 to D=8
    for (int k = 0; k < 6; k++)
      drive(1'b1, k == 0, 1'b0, 4'd2, rnd(), rnd());
    for (int k = 0; k < 24; k++)
      drive(1'b1, k == 0, 1'b0, 4'd3, rnd(), rnd());
    for (int k = 0; k < 8; k++)
      drive(1'b0, 1'b0, 1'b1, 4'd3, rnd(), rnd());

    // async reset pulse mid-frame, then a fresh D=2 frame
    for (int k = 0; k < 10; k++)
      drive(1'b1, k == 0, 1'b0, 4'd3, rnd(), rnd());
    in_valid = 1'b0; flush = 1'b0; in_sop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL arst_valid obs=%b exp=0", out_valid); end
    checks++; assert (out_sop === 1'b0) else begin errors++; $error("FAIL arst_sop obs=%b exp=0", out_sop); end
    checks++; assert ({y0_re, y0_im, y1_re, y1_im} === 64'd0) else begin
      errors++; $error("FAIL arst_y obs=%h exp=0", {y0_re, y0_im, y1_re, y1_im});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++; assert (exp_q.size() === 0) else begin errors++; $error("FAIL arst_queue obs=%0d exp=0", exp_q.size()); end
    for (int k = 0; k < 8; k++)
      drive(1'b1, k == 0, 1'b0, 4'd1, rnd(), rnd());
    drive(1'b0, 1'b0, 1'b1, 4'd1, rnd(), rnd());
    drive(1'b0, 1'b0, 1'b1, 4'd1, rnd(), rnd());

`ifdef FFT_COMM_BYPASS_EN
    // bypass frame: 1-step latency, no fill
    byp_in = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'd3, mk(9, -9), mk(-9, 9));
    byp_in = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd3, rnd(), rnd());
    drive(1'b0, 1'b0, 1'b0, 4'd3, rnd(), rnd());
    drive(1'b0, 1'b0, 1'b1, 4'd3, rnd(), rnd());
    drive(1'b1, 1'b1, 1'b0, 4'd0, mk(11, 12), mk(13, 14));
    drive(1'b1, 1'b0, 1'b0, 4'd0, mk(15, 16), mk(17, 18));
    drive(1'b0, 1'b0, 1'b1, 4'd0, rnd(), rnd());
`endif

    drive(1'b0, 1'b0, 1'b0, 4'd0, rnd(), rnd());
    checks++; assert (exp_q.size() === 0) else begin errors++; $error("FAIL final_queue obs=%0d exp=0", exp_q.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
